swd_phase_engine: RTL

Parametrised successor to the SPI-clocked SWD frontend. It bridges an MCU SPI master (LSB-first, one frame per `rst_n` pulse) to an SWD target. A registered phase state machine replaces the fixed 4-bit counter, so padding length and turnaround length are configurable. It adds ACK status reporting, WAIT/FAULT abort, explicit write-side turnaround, and read-data capture with parity checking. It sits between the MCU SPI pins and the SWD connector.

---
 rtl/swd_phase_engine.sv | 131 +++++++++++++
 1 files changed

// File: rtl/swd_phase_engine.sv
// SPI-clocked SWD phase engine: PAD/REQ/TRN/ACK/DATA/PARITY sequencing on one sck domain.
// Optional read parity checking is built when SWD_PARITY_CHECK_EN is defined.
module swd_phase_engine #(
   parameter int unsigned PAD_BITS   = 3,
   parameter int unsigned TRN_CYCLES = 1
) (
   input  logic        sck,
   input  logic        rst_n,
   input  logic        mosi,
   input  logic        rnw,
   output logic        miso,
   output logic        swclk,
   inout  wire         swdio,
   output logic [2:0]  ack,
   output logic        ack_valid,
   output logic [31:0] rdata,
   output logic        parity_err,
   output logic        done
);

   localparam int unsigned CNT_W    = 6;
   localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_BITS - 1);
   localparam logic [CNT_W-1:0] TRN_LAST = CNT_W'(TRN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [3:0] {
      S_PAD, S_REQ, S_TRN1, S_ACK,
      S_RDATA, S_RPAR, S_TRN2R, S_TAILR,
      S_TRN2W, S_WDATA, S_WPAR, S_TAILW,
      S_ABORT
   } state_t;

   localparam state_t RST_STATE = (PAD_BITS == 0) ? S_REQ : S_PAD;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             oe;
   logic             oe_dec;

   // State register and per-state phase counter (saturating)
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_STATE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Next-state: advance on the edge that completes the current state's length
   always_comb begin
      state_nxt = state;
      case (state)
         S_PAD:   if (cnt == PAD_LAST)      state_nxt = S_REQ;
         S_REQ:   if (cnt == CNT_W'(7))     state_nxt = S_TRN1;
         S_TRN1:  if (cnt == TRN_LAST)      state_nxt = S_ACK;
         S_ACK: begin
            if (cnt == CNT_W'(2)) begin
               if ({swdio, ack[1:0]} == 3'b001)
                  state_nxt = rnw ? S_RDATA : S_TRN2W;
               else
                  state_nxt = S_ABORT;
            end
         end
         S_RDATA: if (cnt == CNT_W'(31))    state_nxt = S_RPAR;
         S_RPAR:                            state_nxt = S_TRN2R;
         S_TRN2R: if (cnt == TRN_LAST)      state_nxt = S_TAILR;
         S_TRN2W: if (cnt == TRN_LAST)      state_nxt = S_WDATA;
         S_WDATA: if (cnt == CNT_W'(31))    state_nxt = S_WPAR;
         S_WPAR:                            state_nxt = S_TAILW;
         default:                           state_nxt = state;
      endcase
   end

   // Output decode: host drives only in its own phases, never during reset
   always_comb begin
      oe_dec = 1'b0;
      case (state)
         S_PAD, S_REQ, S_WDATA, S_WPAR, S_TAILW: oe_dec = 1'b1;
         default:                               oe_dec = 1'b0;
      endcase
      oe = rst_n & oe_dec;
   end

   assign swdio = oe ? mosi : 1'bz;
   assign miso  = swdio;
   assign swclk = sck;

   // Captured status and read data
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         ack       <= '0;
         ack_valid <= 1'b0;
         rdata     <= '0;
         done      <= 1'b0;
      end else begin
         if (state == S_ACK) begin
            ack[cnt[1:0]] <= swdio;
            if (cnt == CNT_W'(2))
               ack_valid <= 1'b1;
         end
         if (state == S_RDATA)
            rdata <= {swdio, rdata[31:1]};
         done <= (state_nxt == S_TAILR) || (state_nxt == S_TAILW) || (state_nxt == S_ABORT);
      end
   end

`ifdef SWD_PARITY_CHECK_EN
   logic par_acc;

   // Running XOR of read data, compared against the target's parity bit
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         par_acc    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (state == S_RDATA)
            par_acc <= par_acc ^ swdio;
         if (state == S_RPAR)
            parity_err <= swdio ^ par_acc;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
